// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for the bit-serial adder sequencer.
// master = producer/consumer side, slave = sequencer side.
interface serial_add_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: accepts a/b/cin, adds LSB-first one bit per
// clock, presents sum/cout/ovf. Ports: clk, rst (async high), abort, busy, io.
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  output logic                busy,
  serial_add_seq_if.slave     io
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] sa, sb, res;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry, cmsb;
  logic             cout_q, ovf_q;

  logic             s_bit, c_new;
  logic [WIDTH-1:0] res_nxt;

  assign s_bit   = sa[0] ^ sb[0] ^ carry;
  assign c_new   = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
  assign res_nxt = {s_bit, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.in_valid) state_d = SHIFT;
      SHIFT: begin
        if (abort)            state_d = IDLE;
        else if (cnt == LAST) state_d = DONE;
      end
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cmsb   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && io.in_valid) begin
        sa    <= io.a;
        sb    <= io.b;
        carry <= io.cin;
        cnt   <= '0;
      end else if (state_q == SHIFT && !abort) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        res   <= res_nxt;
        carry <= c_new;
        cnt   <= cnt + 1'b1;
        // carry leaving bit WIDTH-2 is the carry into the MSB
        if (cnt == PRE) cmsb <= c_new;
        if (cnt == LAST) begin
          sum_q  <= res_nxt;
          cout_q <= c_new;
          ovf_q  <= cmsb ^ c_new;
        end
      end
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign busy         = (state_q == SHIFT);
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq (WIDTH=4).
// Covers latency, arithmetic, backpressure, abort, async reset, back-to-back.
module tb_serial_add_seq;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic busy;

  int passed = 0;
  int total  = 0;

  serial_add_seq_if #(.WIDTH(4)) io ();

  serial_add_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .abort (abort),
    .busy  (busy),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic cin,
                        input logic [3:0] es, input logic ec,
                        input logic eo);
    int k;
    io.a = a;
    io.b = b;
    io.cin = cin;
    io.in_valid = 1'b1;
    chk({tag, "_in_ready"}, io.in_ready, 1);
    tick();
    io.in_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    k = 0;
    while (!io.out_valid && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, 4);
    chk({tag, "_sum"}, io.sum, es);
    chk({tag, "_cout"}, io.cout, ec);
    chk({tag, "_ovf"}, io.ovf, eo);
    tick();
    chk({tag, "_back_idle"}, io.in_ready, 1);
  endtask

  initial begin
    bit ok;
    int acc, res_n, cyc;
    int t_res [3];
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [3:0] xs [3];
    logic       xc [3];

    rst = 1'b1;
    abort = 1'b0;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.cin = 1'b0;
    io.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", io.sum, 0);
    chk("rst_cout", io.cout, 0);
    chk("rst_ovf", io.ovf, 0);
    rst = 1'b0;
    tick();

    run_op("5p4", 4'd5, 4'd4, 1'b0, 4'd9, 1'b0, 1'b1);
    run_op("Fp1", 4'hF, 4'h1, 1'b0, 4'd0, 1'b1, 1'b0);
    run_op("7p0c", 4'h7, 4'h0, 1'b1, 4'd8, 1'b0, 1'b1);

    // backpressure
    io.out_ready = 1'b0;
    io.a = 4'd3;
    io.b = 4'd2;
    io.cin = 1'b0;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_valid", io.out_valid, 1);
    chk("bp_sum", io.sum, 5);
    io.a = 4'd9;
    io.b = 4'd9;
    io.in_valid = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      tick();
      if (io.out_valid !== 1'b1 || io.sum !== 4'd5 || io.in_ready !== 1'b0)
        ok = 1'b0;
    end
    chk("bp_hold", ok, 1);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    tick();
    chk("bp_release_ready", io.in_ready, 1);
    chk("bp_release_valid", io.out_valid, 0);
    tick();
    chk("bp_no_queue", busy, 0);

    // abort on second SHIFT cycle
    io.a = 4'd6;
    io.b = 4'd6;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", io.in_ready, 1);
    chk("abort_sum", io.sum, 5);
    acc = 0;
    repeat (6) begin
      tick();
      if (io.out_valid !== 1'b0) acc++;
    end
    chk("abort_no_valid", acc, 0);
    chk("abort_sum_hold", io.sum, 5);
    run_op("1p1", 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);

    // async reset mid-SHIFT
    io.a = 4'd2;
    io.b = 4'd3;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", io.in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_sum", io.sum, 0);
    chk("arst_out_valid", io.out_valid, 0);
    rst = 1'b0;
    tick();
    run_op("2p3", 4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);

    // back-to-back
    va[0] = 4'd1;  vb[0] = 4'd1;  xs[0] = 4'd2;  xc[0] = 1'b0;
    va[1] = 4'd8;  vb[1] = 4'd8;  xs[1] = 4'd0;  xc[1] = 1'b1;
    va[2] = 4'd15; vb[2] = 4'd15; xs[2] = 4'd14; xc[2] = 1'b1;
    acc = 0;
    res_n = 0;
    cyc = 0;
    io.a = va[0];
    io.b = vb[0];
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    while (res_n < 3 && cyc < 60) begin
      ok = io.in_ready && io.in_valid;
      tick();
      cyc++;
      if (ok) begin
        acc++;
        if (acc < 3) begin
          io.a = va[acc];
          io.b = vb[acc];
        end else begin
          io.in_valid = 1'b0;
        end
      end
      if (io.out_valid) begin
        t_res[res_n] = cyc;
        chk($sformatf("b2b_sum%0d", res_n), io.sum, xs[res_n]);
        chk($sformatf("b2b_cout%0d", res_n), io.cout, xc[res_n]);
        res_n++;
      end
    end
    chk("b2b_count", res_n, 3);
    if (res_n == 3) begin
      chk("b2b_gap01", t_res[1] - t_res[0], 6);
      chk("b2b_gap12", t_res[2] - t_res[1], 6);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
Sequencer for a bit-serial adder. It accepts a WIDTH-bit operand pair through a valid/ready handshake and feeds both operands LSB-first through a single full-adder cell with a carry flop, one bit per clock. It assembles the serial sum bits into a parallel result and presents sum, carry-out and signed overflow through an output valid/ready handshake. It sits between a parallel-word producer and consumer, in place of a free-running bit counter.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand pair a/b/cin is valid
in_ready  output  1  block can accept an operand pair
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
abort  input  1  synchronous cancel of the operation in flight
out_valid  output  1  sum/cout/ovf are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of the MSB
ovf  output  1  signed overflow: carry into the MSB XOR cout
busy  output  1  high in SHIFT state

Behaviour:
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- Reset values: sum=0, cout=0, ovf=0, out_valid=0, busy=0, carry flop=0, bit counter=0, operand shift registers=0. in_ready=1, because it is decoded from the IDLE state.
- Reset asserted mid-operation discards the operation immediately; no out_valid follows.
- Decoded outputs: in_ready = (state==IDLE); busy = (state==SHIFT); out_valid = (state==DONE).
- sum, cout and ovf are registered. They change only on the edge that enters DONE. Otherwise they hold the last result, including across IDLE.
- IDLE, in_valid=1:
  - Latch a and b into shift registers sa and sb.
  - Set carry = cin and counter = 0.
  - Go to SHIFT.
- IDLE, in_valid=0: remain in IDLE. Operands presented outside IDLE are ignored, not queued.
- SHIFT, each edge with abort=0:
  - s = sa[0]^sb[0]^carry.
  - carry <= majority(sa[0], sb[0], carry).
  - Shift sa and sb right by one.
  - Shift s into the MSB of the internal result register, which shifts right.
  - counter += 1.
- SHIFT, capture on the edge where counter == WIDTH-2 (before update): record the carry into the MSB, which is the carry produced by bit WIDTH-2.
- SHIFT, edge where counter == WIDTH-1:
  - The last bit is processed.
  - sum <= completed result, cout <= new carry, ovf <= carry_into_msb ^ new carry.
  - Go to DONE.
- Latency: the acceptance edge is edge 0. Bits are processed on edges 1..WIDTH. out_valid is high from edge WIDTH onward, i.e. WIDTH cycles after acceptance.
- SHIFT, abort=1:
  - Go to IDLE on that edge; no out_valid.
  - sum, cout and ovf keep their previous values.
  - abort is ignored in IDLE and DONE.
- DONE:
  - Hold out_valid=1 and stable outputs until out_ready=1.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready is 0 while in DONE, so at least one IDLE cycle separates operations.
- Back-to-back throughput: one result per WIDTH+2 cycles when in_valid and out_ready are held high.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, exact. The bit counter is $clog2(WIDTH)+1 bits wide and never wraps inside an operation.

Test Plan:
- WIDTH=4, a=4'd5, b=4'd4, cin=0, out_ready=1 -> out_valid rises 4 cycles after acceptance; sum=9, cout=0, ovf=1 (5+4 overflows signed 4-bit).
- a=4'hF, b=4'h1, cin=0 -> sum=0, cout=1, ovf=0; a=4'h7, b=4'h0, cin=1 -> sum=8, cout=0, ovf=1.
- Backpressure: after a=3, b=2, hold out_ready=0 for 6 cycles -> out_valid stays 1, sum stays 5, in_ready stays 0, new in_valid ignored. Release out_ready -> IDLE next edge.
- Abort: abort=1 on the 2nd SHIFT cycle of a=6, b=6 (prior sum=5) -> IDLE next edge, out_valid never asserts, sum still 5. A following a=1, b=1 -> sum=2.
- Reset mid-SHIFT: assert rst asynchronously between edges -> outputs immediately at reset values, in_ready=1. After release, a=2, b=3 -> sum=5 correct.
- Back-to-back: in_valid and out_ready held high with 3 pairs (1+1, 8+8, 15+15) -> results 2/c0, 0/c1, 14/c1, spaced WIDTH+2=6 cycles apart.
